// File: rtl/pa_clic_arb_sched.sv
// pa_clic_arb_sched
// Two-stage CLIC interrupt arbiter and scheduler for 16 sources.
// The sources are split into two halves of 8. ARB1 registers the winner of
// each half. ARB2 compares the two half-winners and registers the final
// winner. PRESENT offers that winner to the CPU until it is taken or it
// becomes ineligible. ACTIVE blocks new presentations until the handler exits.
//
// Optional feature:
//   CLIC_ARB_THRESH_EN : when defined, a source is eligible only if its level
//                        is strictly greater than int_thresh. When undefined,
//                        int_thresh has no effect.
//
// Handshake: the scheduler holds a winner stable while in PRESENT.
// cpu_clic_int_take is a single-cycle pulse that accepts the winner.
// If take and loss of eligibility arrive in the same cycle, take wins.
// cpu_clic_int_exit is a single-cycle pulse. It returns a one-cycle
// ctrl_kid_ack pulse for cpu_clic_curid when that ID is below 16.
module pa_clic_arb_sched #(
    parameter int SRC_NUM  = 16,
    parameter int ID_WIDTH = 12
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [SRC_NUM-1:0]    int_pend,
    input  logic [SRC_NUM-1:0]    int_en,
    input  logic [8*SRC_NUM-1:0]  int_lvl,
    input  logic [SRC_NUM-1:0]    int_hv,
    input  logic [2*SRC_NUM-1:0]  int_priv,
    input  logic [7:0]            int_thresh,
    input  logic                  cpu_clic_int_take,
    input  logic                  cpu_clic_int_exit,
    input  logic [ID_WIDTH-1:0]   cpu_clic_curid,
    output logic [ID_WIDTH-1:0]   clic_int_id,
    output logic [7:0]            clic_int_il_raw,
    output logic                  clic_int_hv,
    output logic [1:0]            clic_int_priv,
    output logic [SRC_NUM-1:0]    ctrl_kid_ack,
    output logic                  sched_busy,
    output logic [2:0]            sched_state
);

    localparam int HALF  = SRC_NUM / 2;
    localparam int IDX_W = $clog2(SRC_NUM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB1    = 3'd1,
        ARB2    = 3'd2,
        PRESENT = 3'd3,
        ACTIVE  = 3'd4
    } state_t;

    state_t            state;

    logic [7:0]        src_lvl [SRC_NUM];
    logic [SRC_NUM-1:0] src_elig;
    logic [7:0]        thresh_eff;

    // combinational half-winners
    logic              lo_vld, hi_vld;
    logic [IDX_W-1:0]  lo_id, hi_id;
    logic [7:0]        lo_lvl, hi_lvl;

    // registered half-winners (ARB1 -> ARB2)
    logic              lo_vld_q, hi_vld_q;
    logic [IDX_W-1:0]  lo_id_q, hi_id_q;
    logic [7:0]        lo_lvl_q, hi_lvl_q;

    // final comparison and registered winner
    logic              fin_vld;
    logic [IDX_W-1:0]  fin_id;
    logic [7:0]        fin_lvl;
    logic [IDX_W-1:0]  win_id_q;
    logic              win_elig;
    logic              curid_in_range;

`ifdef CLIC_ARB_THRESH_EN
    assign thresh_eff = int_thresh;
`else
    // Masking the threshold to zero makes "level > thresh_eff" equal to "level != 0".
    assign thresh_eff = int_thresh & 8'h00;
`endif

    // Unpack the levels and compute per-source eligibility.
    always_comb begin
        src_elig = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            src_lvl[i]  = int_lvl[8*i +: 8];
            src_elig[i] = int_pend[i] & int_en[i] & (src_lvl[i] != 8'd0)
                        & (src_lvl[i] > thresh_eff);
        end
    end

    // Find the lower-half winner. A strict compare keeps the lowest ID on a tie.
    always_comb begin
        lo_vld = 1'b0;
        lo_id  = '0;
        lo_lvl = '0;
        for (int i = 0; i < HALF; i++) begin
            if (src_elig[i] && (!lo_vld || (src_lvl[i] > lo_lvl))) begin
                lo_vld = 1'b1;
                lo_id  = IDX_W'(i);
                lo_lvl = src_lvl[i];
            end
        end
    end

    // Find the upper-half winner with the same lowest-ID tie rule.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        hi_lvl = '0;
        for (int i = HALF; i < SRC_NUM; i++) begin
            if (src_elig[i] && (!hi_vld || (src_lvl[i] > hi_lvl))) begin
                hi_vld = 1'b1;
                hi_id  = IDX_W'(i);
                hi_lvl = src_lvl[i];
            end
        end
    end

    // Final pick. Lower-half IDs are always smaller, so the upper half wins only on a strictly higher level.
    always_comb begin
        fin_vld = lo_vld_q | hi_vld_q;
        if (hi_vld_q && (!lo_vld_q || (hi_lvl_q > lo_lvl_q))) begin
            fin_id  = hi_id_q;
            fin_lvl = hi_lvl_q;
        end else begin
            fin_id  = lo_id_q;
            fin_lvl = lo_lvl_q;
        end
    end

    // Check the current winner's eligibility and the range of the exiting ID.
    always_comb begin
        win_elig       = src_elig[win_id_q];
        curid_in_range = (cpu_clic_curid < ID_WIDTH'(SRC_NUM));
    end

    // Scheduler FSM, arbitration pipeline registers, registered outputs and ack pulse.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state           <= IDLE;
            lo_vld_q        <= 1'b0;
            hi_vld_q        <= 1'b0;
            lo_id_q         <= '0;
            hi_id_q         <= '0;
            lo_lvl_q        <= '0;
            hi_lvl_q        <= '0;
            win_id_q        <= '0;
            clic_int_id     <= '0;
            clic_int_il_raw <= '0;
            clic_int_hv     <= 1'b0;
            clic_int_priv   <= '0;
            ctrl_kid_ack    <= '0;
        end else begin
            ctrl_kid_ack <= '0;
            if (cpu_clic_int_exit && curid_in_range) begin
                ctrl_kid_ack[cpu_clic_curid[IDX_W-1:0]] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|src_elig) begin
                        state <= ARB1;
                    end
                end
                ARB1: begin
                    lo_vld_q <= lo_vld;
                    lo_id_q  <= lo_id;
                    lo_lvl_q <= lo_lvl;
                    hi_vld_q <= hi_vld;
                    hi_id_q  <= hi_id;
                    hi_lvl_q <= hi_lvl;
                    state    <= ARB2;
                end
                ARB2: begin
                    if (fin_vld) begin
                        win_id_q        <= fin_id;
                        clic_int_id     <= ID_WIDTH'(fin_id);
                        clic_int_il_raw <= fin_lvl;
                        clic_int_hv     <= int_hv[fin_id];
                        clic_int_priv   <= int_priv[2*fin_id +: 2];
                        state           <= PRESENT;
                    end else begin
                        state <= IDLE;
                    end
                end
                PRESENT: begin
                    if (cpu_clic_int_take) begin
                        clic_int_il_raw <= '0;
                        state           <= ACTIVE;
                    end else if (!win_elig) begin
                        clic_int_il_raw <= '0;
                        state           <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (cpu_clic_int_exit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    clic_int_il_raw <= '0;
                    state           <= IDLE;
                end
            endcase
        end
    end

    assign sched_busy  = (state != IDLE);
    assign sched_state = state;

endmodule

// File: tb/tb_pa_clic_arb_sched.sv
// Directed testbench for pa_clic_arb_sched.
// Each vector carries a hand-computed expected value.
module tb_pa_clic_arb_sched;

    localparam int SRC_NUM  = 16;
    localparam int ID_WIDTH = 12;

    logic                 forever_cpuclk;
    logic                 cpurst_b;
    logic [SRC_NUM-1:0]   int_pend;
    logic [SRC_NUM-1:0]   int_en;
    logic [8*SRC_NUM-1:0] int_lvl;
    logic [SRC_NUM-1:0]   int_hv;
    logic [2*SRC_NUM-1:0] int_priv;
    logic [7:0]           int_thresh;
    logic                 cpu_clic_int_take;
    logic                 cpu_clic_int_exit;
    logic [ID_WIDTH-1:0]  cpu_clic_curid;
    logic [ID_WIDTH-1:0]  clic_int_id;
    logic [7:0]           clic_int_il_raw;
    logic                 clic_int_hv;
    logic [1:0]           clic_int_priv;
    logic [SRC_NUM-1:0]   ctrl_kid_ack;
    logic                 sched_busy;
    logic [2:0]           sched_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ID_WIDTH-1:0] exp_q[$];

    localparam logic [31:0] S_IDLE    = 32'd0;
    localparam logic [31:0] S_ARB1    = 32'd1;
    localparam logic [31:0] S_ARB2    = 32'd2;
    localparam logic [31:0] S_PRESENT = 32'd3;
    localparam logic [31:0] S_ACTIVE  = 32'd4;

    pa_clic_arb_sched #(.SRC_NUM(SRC_NUM), .ID_WIDTH(ID_WIDTH)) dut (
        .forever_cpuclk    (forever_cpuclk),
        .cpurst_b          (cpurst_b),
        .int_pend          (int_pend),
        .int_en            (int_en),
        .int_lvl           (int_lvl),
        .int_hv            (int_hv),
        .int_priv          (int_priv),
        .int_thresh        (int_thresh),
        .cpu_clic_int_take (cpu_clic_int_take),
        .cpu_clic_int_exit (cpu_clic_int_exit),
        .cpu_clic_curid    (cpu_clic_curid),
        .clic_int_id       (clic_int_id),
        .clic_int_il_raw   (clic_int_il_raw),
        .clic_int_hv       (clic_int_hv),
        .clic_int_priv     (clic_int_priv),
        .ctrl_kid_ack      (ctrl_kid_ack),
        .sched_busy        (sched_busy),
        .sched_state       (sched_state)
    );

    // clock / reset
    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    // checking
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // drivers
    task automatic step(input int n);
        repeat (n) @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic clear_srcs();
        int_pend = '0;
        int_en   = '0;
        int_lvl  = '0;
        int_hv   = '0;
        int_priv = '0;
    endtask

    task automatic set_src(input int idx, input logic [7:0] lvl, input logic hv, input logic [1:0] priv);
        int_pend[idx]          = 1'b1;
        int_en[idx]            = 1'b1;
        int_lvl[8*idx +: 8]    = lvl;
        int_hv[idx]            = hv;
        int_priv[2*idx +: 2]   = priv;
    endtask

    task automatic pulse_exit(input logic [ID_WIDTH-1:0] id);
        cpu_clic_int_exit = 1'b1;
        cpu_clic_curid    = id;
        step(1);
        cpu_clic_int_exit = 1'b0;
        cpu_clic_curid    = '0;
    endtask

    initial begin
        clear_srcs();
        int_thresh        = 8'h00;
        cpu_clic_int_take = 1'b0;
        cpu_clic_int_exit = 1'b0;
        cpu_clic_curid    = '0;
        cpurst_b          = 1'b0;
        step(2);

        // reset state
        check_eq("rst_state", 32'(sched_state), S_IDLE);
        check_eq("rst_busy",  32'(sched_busy), 32'd0);
        check_eq("rst_il",    32'(clic_int_il_raw), 32'd0);
        check_eq("rst_id",    32'(clic_int_id), 32'd0);
        check_eq("rst_ack",   32'(ctrl_kid_ack), 32'd0);
        cpurst_b = 1'b1;
        step(1);
        check_eq("idle_quiet", 32'(sched_state), S_IDLE);

        // single source 3 at 0x40
        set_src(3, 8'h40, 1'b1, 2'd3);
        exp_q.push_back(12'd3);
        step(1);
        check_eq("t1_arb1_state", 32'(sched_state), S_ARB1);
        check_eq("t1_arb1_il",    32'(clic_int_il_raw), 32'd0);
        check_eq("t1_busy",       32'(sched_busy), 32'd1);
        step(3);
        check_eq("t1_present", 32'(sched_state), S_PRESENT);
        check_eq("t1_id",      32'(clic_int_id), 32'(exp_q.pop_front()));
        check_eq("t1_il",      32'(clic_int_il_raw), 32'h40);
        check_eq("t1_hv",      32'(clic_int_hv), 32'd1);
        check_eq("t1_priv",    32'(clic_int_priv), 32'd3);
        // the winner loses pend without a take, so the FSM returns to IDLE and the id is held
        clear_srcs();
        step(1);
        check_eq("t1_drop_state", 32'(sched_state), S_IDLE);
        check_eq("t1_drop_il",    32'(clic_int_il_raw), 32'd0);
        check_eq("t1_drop_id",    32'(clic_int_id), 32'd3);

        // sources 2 and 9 tie at 0x80, so the lower ID wins
        set_src(2, 8'h80, 1'b0, 2'd0);
        set_src(9, 8'h80, 1'b0, 2'd1);
        exp_q.push_back(12'd2);
        step(4);
        check_eq("t2_tie_id", 32'(clic_int_id), 32'(exp_q.pop_front()));
        check_eq("t2_tie_il", 32'(clic_int_il_raw), 32'h80);
        clear_srcs();
        step(1);
        set_src(2, 8'h80, 1'b0, 2'd0);
        set_src(9, 8'h81, 1'b1, 2'd1);
        exp_q.push_back(12'd9);
        step(4);
        check_eq("t2_hi_id",   32'(clic_int_id), 32'(exp_q.pop_front()));
        check_eq("t2_hi_il",   32'(clic_int_il_raw), 32'h81);
        check_eq("t2_hi_priv", 32'(clic_int_priv), 32'd1);

        // take, then hold in ACTIVE with requests still pending, then exit with curid 9
        cpu_clic_int_take = 1'b1;
        step(1);
        cpu_clic_int_take = 1'b0;
        check_eq("t3_active", 32'(sched_state), S_ACTIVE);
        check_eq("t3_il0",    32'(clic_int_il_raw), 32'd0);
        check_eq("t3_id_hold", 32'(clic_int_id), 32'd9);
        step(2);
        check_eq("t3_no_nest", 32'(sched_state), S_ACTIVE);
        clear_srcs();
        pulse_exit(12'd9);
        check_eq("t3_ack",        32'(ctrl_kid_ack), 32'h0200);
        check_eq("t3_exit_state", 32'(sched_state), S_IDLE);
        step(1);
        check_eq("t3_ack_gone", 32'(ctrl_kid_ack), 32'd0);

        // exit in IDLE: an out-of-range ID gives no ack, and ID 0 acks bit 0
        pulse_exit(12'd20);
        check_eq("t3_oor_ack", 32'(ctrl_kid_ack), 32'd0);
        pulse_exit(12'd0);
        check_eq("t3_id0_ack",   32'(ctrl_kid_ack), 32'h0001);
        check_eq("t3_id0_state", 32'(sched_state), S_IDLE);

        // exit in PRESENT acks but does not change state
        set_src(5, 8'h10, 1'b0, 2'd1);
        step(4);
        check_eq("t4_present", 32'(sched_state), S_PRESENT);
        check_eq("t4_id",      32'(clic_int_id), 32'd5);
        pulse_exit(12'd7);
        check_eq("t4_exit_ack",   32'(ctrl_kid_ack), 32'h0080);
        check_eq("t4_exit_state", 32'(sched_state), S_PRESENT);
        // take arrives together with enable drop, so take wins
        int_en[5]         = 1'b0;
        cpu_clic_int_take = 1'b1;
        step(1);
        cpu_clic_int_take = 1'b0;
        check_eq("t4_take_wins", 32'(sched_state), S_ACTIVE);
        clear_srcs();
        pulse_exit(12'd5);
        check_eq("t4_ack", 32'(ctrl_kid_ack), 32'h0020);
        // enable drop without take returns to IDLE
        set_src(5, 8'h10, 1'b0, 2'd1);
        step(4);
        check_eq("t4_re_present", 32'(sched_state), S_PRESENT);
        int_en[5] = 1'b0;
        step(1);
        check_eq("t4_drop_state", 32'(sched_state), S_IDLE);
        check_eq("t4_drop_il",    32'(clic_int_il_raw), 32'd0);
        clear_srcs();
        step(1);

        // threshold behaviour
`ifdef CLIC_ARB_THRESH_EN
        int_thresh = 8'h50;
        set_src(1, 8'h50, 1'b0, 2'd0);
        step(4);
        check_eq("t5_eq_thresh_idle", 32'(sched_state), S_IDLE);
        int_lvl[15:8] = 8'h51;
        step(4);
        check_eq("t5_above_present", 32'(sched_state), S_PRESENT);
        check_eq("t5_above_il",      32'(clic_int_il_raw), 32'h51);
`else
        int_thresh = 8'hFF;
        set_src(1, 8'h50, 1'b0, 2'd0);
        step(4);
        check_eq("t5_thresh_ignored", 32'(sched_state), S_PRESENT);
        check_eq("t5_thresh_il",      32'(clic_int_il_raw), 32'h50);
`endif
        clear_srcs();
        int_thresh = 8'h00;
        step(1);
        check_eq("t5_back_idle", 32'(sched_state), S_IDLE);

        // reset asserted in ARB2 abandons the interrupt
        set_src(4, 8'h22, 1'b1, 2'd2);
        step(2);
        check_eq("t6_arb2", 32'(sched_state), S_ARB2);
        cpurst_b          = 1'b0;
        cpu_clic_int_exit = 1'b1;
        cpu_clic_curid    = 12'd4;
        step(1);
        cpu_clic_int_exit = 1'b0;
        cpu_clic_curid    = '0;
        check_eq("t6_rst_state", 32'(sched_state), S_IDLE);
        check_eq("t6_rst_id",    32'(clic_int_id), 32'd0);
        check_eq("t6_rst_il",    32'(clic_int_il_raw), 32'd0);
        check_eq("t6_rst_hv",    32'(clic_int_hv), 32'd0);
        check_eq("t6_rst_priv",  32'(clic_int_priv), 32'd0);
        check_eq("t6_rst_ack",   32'(ctrl_kid_ack), 32'd0);
        check_eq("t6_rst_busy",  32'(sched_busy), 32'd0);
        clear_srcs();
        cpurst_b = 1'b1;
        step(1);
        check_eq("t6_post_ack",   32'(ctrl_kid_ack), 32'd0);
        check_eq("t6_post_state", 32'(sched_state), S_IDLE);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_clic_arb_sched.md
PA_CLIC_ARB_SCHED -- requirements
Module: pa_clic_arb_sched

Interface
REQ-001 SHALL have parameter SRC_NUM, default 16, meaning number of arbitrated interrupt sources (fixed 16 in this release).
REQ-002 SHALL have parameter ID_WIDTH, default 12, meaning width of interrupt ID buses.
REQ-003 SHALL have port forever_cpuclk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpurst_b  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port int_pend  in  16  per-source level pending request.
REQ-006 SHALL have port int_en  in  16  per-source enable.
REQ-007 SHALL have port int_lvl  in  128  8-bit level per source; source i at bits [8i+7:8i].
REQ-008 SHALL have port int_hv  in  16  per-source hardware-vectored flag.
REQ-009 SHALL have port int_priv  in  32  2-bit privilege per source; source i at bits [2i+1:2i].
REQ-010 SHALL have port int_thresh  in  8  minimum level threshold.
REQ-011 SHALL have port cpu_clic_int_take  in  1  CPU accepted presented interrupt (pulse).
REQ-012 SHALL have port cpu_clic_int_exit  in  1  CPU exited handler (pulse).
REQ-013 SHALL have port cpu_clic_curid  in  12  ID of exiting interrupt.
REQ-014 SHALL have ports clic_int_id (out 12), clic_int_il_raw (out 8), clic_int_hv (out 1), clic_int_priv (out 2): presented winner.
REQ-015 SHALL have port ctrl_kid_ack  out  16  one-hot pending-clear pulse to source gateways.
REQ-016 SHALL have port sched_busy  out  1  high when state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ARB1, ARB2, PRESENT, ACTIVE.
REQ-018 Eligible(i) SHALL be int_pend[i] & int_en[i] & (level != 0).
REQ-019 IDLE -> ARB1 when any source eligible; else stay.
REQ-020 ARB1 SHALL register the winner of sources 0-7 and of sources 8-15 separately (highest level; tie -> lowest ID); ARB1 -> ARB2 unconditionally.
REQ-021 ARB2 SHALL compare the two registered half-winners (tie -> lower ID) and register the final winner; -> PRESENT if a winner exists, else -> IDLE.
REQ-022 Outputs SHALL be valid in PRESENT: request sampled at edge k yields PRESENT and nonzero clic_int_il_raw after edge k+3.
REQ-023 clic_int_il_raw SHALL be zero in every state other than PRESENT; id/hv/priv hold last winner.
REQ-024 PRESENT -> ACTIVE on cpu_clic_int_take; PRESENT -> IDLE if winner loses eligibility without take.
REQ-025 Simultaneous take and winner de-eligibility SHALL resolve as take (-> ACTIVE).
REQ-026 ACTIVE SHALL hold until cpu_clic_int_exit; no nesting, new requests wait.
REQ-027 On cpu_clic_int_exit in any state, ctrl_kid_ack SHALL pulse bit cpu_clic_curid for exactly the next cycle when curid < 16; zero otherwise.
REQ-028 Exit in ACTIVE SHALL move to IDLE; exit in other states SHALL not change state.
REQ-029 Level arithmetic SHALL be unsigned 8-bit compare; no wrap or saturation applies.

Reset
REQ-030 With cpurst_b low at a clock edge: state IDLE, all outputs zero, winner registers cleared.
REQ-031 Reset asserted mid-arbitration or in ACTIVE SHALL abandon the interrupt with no ack pulse.

Configuration
REQ-032 Macro CLIC_ARB_THRESH_EN defined: eligibility additionally SHALL require level > int_thresh, re-checked in PRESENT per REQ-024.
REQ-033 Macro CLIC_ARB_THRESH_EN undefined: int_thresh SHALL be ignored.

Verification
REQ-034 Source 3 level 0x40 pend/en at edge k -> PRESENT after k+3, id=3, il=0x40.
REQ-035 Sources 2 and 9 both level 0x80 -> id=2; source 9 at 0x81 -> id=9.
REQ-036 Take in PRESENT then exit with curid=9 -> il=0 in ACTIVE, ctrl_kid_ack=0x0200 one cycle, state IDLE.
REQ-037 Winner's int_en dropped in PRESENT with take same cycle -> ACTIVE; without take -> IDLE, il=0.
REQ-038 CLIC_ARB_THRESH_EN, thresh=0x50, only source 1 at 0x50 -> stays IDLE; level 0x51 -> presented.
REQ-039 Reset asserted in ARB2 -> next cycle IDLE, all outputs zero, no ack.
